// File: rtl/frontend_bus_arbiter_pkg.sv
// Shared bus query types plus the arbiter's state and owner encodings
// for the frontend/LSU memory port arbiter.
package frontend_bus_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_query_req_t;

  typedef struct packed {
    logic        ready;
    logic        err;
    logic [31:0] rdata;
  } bus_query_resp_t;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_OWN_IFU = 2'd1,
    ARB_OWN_LSU = 2'd2,
    ARB_DRAIN   = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWNER_NONE  = 2'd0,
    OWNER_IFU   = 2'd1,
    OWNER_LSU   = 2'd2,
    OWNER_DRAIN = 2'd3
  } arb_owner_t;

  function automatic arb_owner_t state_owner(input arb_state_t s);
    case (s)
      ARB_OWN_IFU: return OWNER_IFU;
      ARB_OWN_LSU: return OWNER_LSU;
      ARB_DRAIN:   return OWNER_DRAIN;
      default:     return OWNER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/frontend_bus_arbiter.sv
// Arbitrates the single memory port between IFU and LSU: LSU-priority with
// an IFU anti-starvation bound, and drain-on-flush for aborted IFU traffic.
module frontend_bus_arbiter
  import frontend_bus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  bus_query_req_t  ifu_req,
  output bus_query_resp_t ifu_resp,
  input  logic            ifu_abort,
  input  bus_query_req_t  lsu_req,
  output bus_query_resp_t lsu_resp,
  output bus_query_req_t  bus_req,
  input  bus_query_resp_t bus_resp,
  output logic [1:0]      owner,
  output logic            arb_busy
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t       state, state_nxt;
  bus_query_req_t   held, held_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
  logic             ifu_eligible;
  logic             lsu_win;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      held       <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      held       <= held_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    held_nxt       = held;
    starve_cnt_nxt = starve_cnt;
    ifu_eligible   = ifu_req.valid & ~ifu_abort;
    lsu_win        = lsu_req.valid & ~(ifu_eligible & (starve_cnt == STARVE_MAX));

    case (state)
      ARB_IDLE: begin
        if (!ifu_eligible) starve_cnt_nxt = '0;
        if (lsu_win) begin
          state_nxt = ARB_OWN_LSU;
          held_nxt  = lsu_req;
          if (ifu_eligible && (starve_cnt != STARVE_MAX))
            starve_cnt_nxt = starve_cnt + 1'b1;
        end else if (ifu_eligible) begin
          state_nxt      = ARB_OWN_IFU;
          held_nxt       = ifu_req;
          starve_cnt_nxt = '0;
        end
      end
      ARB_OWN_IFU: begin
        // A completion in the abort cycle wins over draining; the data is dropped.
        if (bus_resp.ready)  state_nxt = ARB_IDLE;
        else if (ifu_abort)  state_nxt = ARB_DRAIN;
      end
      ARB_OWN_LSU: begin
        if (bus_resp.ready) state_nxt = ARB_IDLE;
      end
      ARB_DRAIN: begin
        if (bus_resp.ready) state_nxt = ARB_IDLE;
      end
    endcase
  end

  always_comb begin
    bus_req  = '0;
    ifu_resp = '0;
    lsu_resp = '0;
    if (state != ARB_IDLE) bus_req = held;
    if ((state == ARB_OWN_IFU) && bus_resp.ready && !ifu_abort) ifu_resp = bus_resp;
    if ((state == ARB_OWN_LSU) && bus_resp.ready) lsu_resp = bus_resp;
  end

  assign owner    = state_owner(state);
  assign arb_busy = (state != ARB_IDLE);

endmodule
